framing_sched: RTL and testbench
================================

FRAMING_SCHED -- requirements
Module: framing_sched

Interface
REQ-001 Parameter: IFS_CYCLES, default 4, idle cycles inserted after each frame before the next grant.
REQ-002 Parameter: FCS_TIMEOUT, default 20, max FCS_WAIT cycles (only with FRAMING_SCHED_TIMEOUT_EN).
REQ-003 clk  in  1  single clock, all state on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  2  per-requester frame request, level.
REQ-006 len0, len1  in  7 each  PSDU byte count of requester 0/1, range 0..127.
REQ-007 din0, din1  in  8 each  current PSDU byte of requester 0/1.
REQ-008 grant  out  2  one-hot, held for the whole frame.
REQ-009 byte_rd  out  2  one-cycle pulse: current PSDU byte consumed, present next byte next cycle.
REQ-010 done  out  2  one-cycle pulse on frame completion for the granted requester.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 frm_din  out  8  byte to framer.
REQ-013 frm_indicator  out  1  framer start/end strobe.
REQ-014 frm_next_indicator  in  1  framer completion indication.
REQ-015 err  out  1  one-cycle pulse on FCS timeout (TIMEOUT_EN only, else tied 0).

Function
REQ-016 States: IDLE, START, SHR_WAIT, PHR, PSDU, FCS_WAIT, GAP.
REQ-017 IDLE: if any req high, next state START; winner by round-robin pointer; grant and latched length registered on that edge.
REQ-018 Round-robin: single req wins; both high -> requester other than last served wins; pointer after reset = requester 0 favoured.
REQ-019 START: exactly 1 cycle, frm_indicator=1, frm_din=0.
REQ-020 SHR_WAIT: exactly 80 cycles, frm_din=0, frm_indicator=0.
REQ-021 PHR: 8 cycles, frm_din={1'b0, latched len}.
REQ-022 PSDU: 8 cycles per byte, frm_din = granted din held constant; byte_rd pulses on the 8th cycle of each byte.
REQ-023 frm_indicator=1 on the 8th cycle of the final byte (last PSDU byte, or PHR if len=0); next state FCS_WAIT.
REQ-024 FCS_WAIT: frm_din=0, frm_indicator=0; on frm_next_indicator=1 pulse done, drop grant, next state GAP.
REQ-025 GAP: IFS_CYCLES cycles, then IDLE; req ignored during GAP.
REQ-026 Frame length from START to done: 1+80+8+8*len+16 cycles with a compliant framer.
REQ-027 req deassert or len/req change after grant: ignored; frame completes with latched length.
REQ-028 frm_next_indicator outside FCS_WAIT: ignored.
REQ-029 Bit counter 3-bit wrap, byte counter 7-bit; len=127 completes without overflow.

Reset
REQ-030 reset_n low: state IDLE, grant=0, byte_rd=0, done=0, busy=0, frm_din=0, frm_indicator=0, err=0, counters 0, pointer favours requester 0.
REQ-031 Reset mid-frame aborts immediately; no done pulse; first post-reset frame starts cleanly.

Configuration
REQ-032 Macro FRAMING_SCHED_TIMEOUT_EN defined: FCS_WAIT counts cycles; no frm_next_indicator within FCS_TIMEOUT cycles -> err pulse, grant dropped, no done, next state GAP.
REQ-033 Macro undefined: FCS_WAIT waits indefinitely; err constant 0; no timeout counter.

Verification
REQ-034 req=01, len0=2, din0 A5 then 3C, framer model attached -> frm_indicator at START, 80 zero cycles, PHR 02, A5x8, 3Cx8, indicator on final 3C cycle, done=01 at cycle 121 after START.
REQ-035 req=11 continuously after reset -> grants alternate 01,10,01 with IFS_CYCLES=4 idle gap between done and next START.
REQ-036 len0=0 -> PHR 00 for 8 cycles, frm_indicator on 8th PHR cycle, no byte_rd pulses, done 105 cycles after START.
REQ-037 reset_n low during PSDU byte 5 -> all outputs 0 asynchronously, no done; next req starts at START normally.
REQ-038 TIMEOUT_EN, framer never asserts frm_next_indicator -> err pulse after 20 FCS_WAIT cycles, grant 0, IDLE after 4 GAP cycles; without macro -> busy stays 1.
REQ-039 len1=127 -> exactly 127 byte_rd pulses, 8 cycles apart, done 1121 cycles after START.

Source files
------------

// File: rtl/framing_sched.sv
// framing_sched: arbitrates two frame requesters and sequences the granted one
// through a PHY framer (start strobe, SHR wait, PHR, PSDU bytes, FCS wait, gap).
// Optional build macro FRAMING_SCHED_TIMEOUT_EN bounds FCS_WAIT to FCS_TIMEOUT
// cycles and pulses err on expiry; without it err is tied low and FCS_WAIT
// waits for the framer indefinitely.
module framing_sched #(
   parameter int IFS_CYCLES  = 4,
   parameter int FCS_TIMEOUT = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic [6:0] len0,
   input  logic [6:0] len1,
   input  logic [7:0] din0,
   input  logic [7:0] din1,
   output logic [1:0] grant,
   output logic [1:0] byte_rd,
   output logic [1:0] done,
   output logic       busy,
   output logic [7:0] frm_din,
   output logic       frm_indicator,
   input  logic       frm_next_indicator,
   output logic       err
);

   localparam int SHR_CYCLES = 80;
   // One shared cycle counter serves SHR_WAIT, GAP and (optionally) FCS_WAIT.
   localparam int MAX_A   = (IFS_CYCLES > SHR_CYCLES) ? IFS_CYCLES : SHR_CYCLES;
   localparam int CNT_MAX = (FCS_TIMEOUT > MAX_A) ? FCS_TIMEOUT : MAX_A;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SHR_LAST = CNT_W'(SHR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IFS_CYCLES - 1);
`ifdef FRAMING_SCHED_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FCS_TIMEOUT - 1);
`endif

   typedef enum logic [2:0] {
      IDLE, START, SHR_WAIT, PHR, PSDU, FCS_WAIT, GAP
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic [6:0]       len_q, len_d;
   logic [6:0]       byte_q, byte_d;
   logic [2:0]       bit_q, bit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;   // 1: requester 1 served last, so 0 wins a tie

   // State register: every piece of sequential state, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         len_q   <= '0;
         byte_q  <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q <= state_d;
         grant_q <= grant_d;
         len_q   <= len_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic: arbitration, phase sequencing and counters.
   always_comb begin
      // NOTE: hold-by-default assignments keep this block free of latches.
      state_d = state_q;
      grant_d = grant_q;
      len_d   = len_q;
      byte_d  = byte_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = START;
               cnt_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               if (req[0] && (!req[1] || last_q)) begin
                  grant_d = 2'b01;
                  len_d   = len0;
                  last_d  = 1'b0;
               end else begin
                  grant_d = 2'b10;
                  len_d   = len1;
                  last_d  = 1'b1;
               end
            end
         end
         START: state_d = SHR_WAIT;
         SHR_WAIT: begin
            if (cnt_q == SHR_LAST) begin
               state_d = PHR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PHR: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (len_q == '0) ? FCS_WAIT : PSDU;
         end
         PSDU: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
               if (byte_q == len_q - 7'd1) state_d = FCS_WAIT;
               else                        byte_d  = byte_q + 7'd1;
            end
         end
         FCS_WAIT: begin
            if (frm_next_indicator) begin
               state_d = GAP;
               grant_d = '0;
               cnt_d   = '0;
            end
`ifdef FRAMING_SCHED_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               state_d = GAP;
               grant_d = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

   // Output decode: framer data/strobe and per-requester pulses from the current phase.
   always_comb begin
      byte_rd       = '0;
      done          = '0;
      err           = 1'b0;
      frm_din       = '0;
      frm_indicator = 1'b0;
      case (state_q)
         START: frm_indicator = 1'b1;
         PHR: begin
            frm_din       = {1'b0, len_q};
            frm_indicator = (len_q == '0) && (bit_q == 3'd7);
         end
         PSDU: begin
            frm_din = grant_q[1] ? din1 : din0;
            if (bit_q == 3'd7) begin
               byte_rd       = grant_q;
               frm_indicator = (byte_q == len_q - 7'd1);
            end
         end
         FCS_WAIT: begin
            if (frm_next_indicator) done = grant_q;
`ifdef FRAMING_SCHED_TIMEOUT_EN
            err = !frm_next_indicator && (cnt_q == TMO_LAST);
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_framing_sched.sv
// Bench for framing_sched: stimulus pushes the expected frame record into a
// scoreboard queue; a monitor builds the observed record per frame and
// compares on each done/err pulse. A framer model answers 17 cycles after the
// end strobe, giving done at 1+80+8+8*len+16 cycles after START.
module tb_framing_sched;

   localparam int IFS = 4;
   localparam int TMO = 20;

   logic       clk;
   logic       reset_n;
   logic [1:0] req;
   logic [6:0] len0, len1;
   logic [7:0] din0, din1;
   logic [1:0] grant, byte_rd, done;
   logic       busy, frm_indicator, frm_next_indicator, err;
   logic [7:0] frm_din;

   logic fr_ind, spur_ind, framer_en;
   assign frm_next_indicator = fr_ind | spur_ind;

   framing_sched #(.IFS_CYCLES(IFS), .FCS_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .len0(len0), .len1(len1),
      .din0(din0), .din1(din1), .grant(grant), .byte_rd(byte_rd), .done(done),
      .busy(busy), .frm_din(frm_din), .frm_indicator(frm_indicator),
      .frm_next_indicator(frm_next_indicator), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] byte_val(input int r, input int i);
      if (r == 0) begin
         if (i == 0) return 8'hA5;
         if (i == 1) return 8'h3C;
         return 8'(i * 5 + 1);
      end
      return 8'(8'h40 + i);
   endfunction

   typedef struct {
      logic [1:0] grant;
      bit         is_err;
      int         done_at;
      int         n_rd;
      int         end_ind;
      logic [7:0] phr;
      int         sig;
      int         gap;
   } exp_t;

   exp_t sb[$];

   // Expected record from the frame formulas; sig = sum of frm_din over the frame.
   task automatic push(input logic [1:0] g, input int r, input int len,
                       input bit is_err, input int gap);
      exp_t e;
      e.grant   = g;
      e.is_err  = is_err;
      e.n_rd    = len;
      e.end_ind = (len == 0) ? 88 : 88 + 8 * len;
      e.done_at = is_err ? 89 + 8 * len + TMO - 1 : 105 + 8 * len;
      e.phr     = 8'(len);
      e.sig     = 8 * len;
      for (int i = 0; i < len; i++) e.sig += 8 * int'(byte_val(r, i));
      e.gap     = gap;
      sb.push_back(e);
   endtask

   // PSDU source: advance the byte index after each byte_rd, rewind between frames.
   int idx0 = 0, idx1 = 0;
   initial begin
      din0 = byte_val(0, 0);
      din1 = byte_val(1, 0);
      forever begin
         logic rd0, rd1, idle;
         @(negedge clk);
         rd0  = byte_rd[0];
         rd1  = byte_rd[1];
         idle = (grant == 2'b00);
         @(posedge clk);
         #1;
         if (idle) begin
            idx0 = 0;
            idx1 = 0;
         end else begin
            if (rd0) idx0++;
            if (rd1) idx1++;
         end
         din0 = byte_val(0, idx0);
         din1 = byte_val(1, idx1);
      end
   end

   // Framer model: second strobe of a frame is the end; answer 17 cycles later.
   initial begin
      bit in_frame;
      in_frame = 1'b0;
      fr_ind   = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_frame = 1'b0;
         end else if (frm_indicator) begin
            if (!in_frame) begin
               in_frame = 1'b1;
            end else begin
               in_frame = 1'b0;
               if (framer_en) begin
                  repeat (17) @(posedge clk);
                  #1 fr_ind = 1'b1;
                  @(posedge clk);
                  #1 fr_ind = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: accumulate the observed frame and compare on done/err.
   int         start_cyc = 0, n_rd = 0, sig = 0, ind_cnt = 0, end_ind = -1;
   int         last_rd = -1, gap_meas = -1, last_done_cyc = -1;
   int         n_start = 0, n_evt = 0, evt_cyc = 0;
   bit         rd_gap_ok = 1'b1, rd_sel_ok = 1'b1;
   logic [7:0] phr = '0;
   logic [1:0] prev_grant = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_grant    = '0;
            last_done_cyc = -1;
         end else begin
            if (prev_grant == 2'b00 && grant != 2'b00) begin
               start_cyc = cyc;
               n_rd      = 0;
               sig       = 0;
               ind_cnt   = 0;
               end_ind   = -1;
               last_rd   = -1;
               rd_gap_ok = 1'b1;
               rd_sel_ok = 1'b1;
               phr       = '0;
               gap_meas  = (last_done_cyc < 0) ? -1 : cyc - last_done_cyc;
               n_start++;
            end
            if (grant != 2'b00) begin
               sig += int'(frm_din);
               if (cyc - start_cyc == 81) phr = frm_din;
               if (frm_indicator) begin
                  ind_cnt++;
                  if (cyc != start_cyc) end_ind = cyc - start_cyc;
               end
               if (byte_rd != 2'b00) begin
                  if (byte_rd != grant) rd_sel_ok = 1'b0;
                  if (last_rd >= 0 && cyc - last_rd != 8) rd_gap_ok = 1'b0;
                  last_rd = cyc;
                  n_rd++;
               end
            end
            if (done != 2'b00 || err) begin
               n_evt++;
               evt_cyc       = cyc;
               last_done_cyc = cyc;
               if (sb.size() == 0) begin
                  check("unexpected_done_or_err", 32'({done, err}), 0);
               end else begin
                  e = sb.pop_front();
                  check("grant_at_end", 32'(err ? grant : done), 32'(e.grant));
                  check("done_vs_err", 32'({done != 2'b00, err}), e.is_err ? 1 : 2);
                  check("end_cycle", cyc - start_cyc, e.done_at);
                  check("byte_rd_count", n_rd, e.n_rd);
                  check("byte_rd_spacing", 32'(rd_gap_ok), 1);
                  check("byte_rd_owner", 32'(rd_sel_ok), 1);
                  check("end_strobe_cycle", end_ind, e.end_ind);
                  check("strobe_count", ind_cnt, 2);
                  check("phr_byte", 32'(phr), 32'(e.phr));
                  check("frame_signature", sig, e.sig);
                  if (e.gap >= 0) check("ifs_gap", gap_meas, e.gap);
               end
            end
            prev_grant = grant;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int target);
      int k = 0;
      while (n_start < target && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("start_within_budget", 32'(n_start >= target), 1);
   endtask

   task automatic wait_evt(input int target);
      int k = 0;
      while (n_evt < target && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("end_within_budget", 32'(n_evt >= target), 1);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({grant, byte_rd, done, busy, frm_din, frm_indicator, err});
   endfunction

   initial begin
      #(10 * 20000);
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      req       = 2'b00;
      len0      = '0;
      len1      = '0;
      spur_ind  = 1'b0;
      framer_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 0);
      tick();
      reset_n = 1'b1;
      repeat (2) tick();

      // Two-byte frame from requester 0 (A5, 3C); done 121 cycles after START.
      // req dropped and len0 changed after grant; a stray framer pulse during SHR.
      push(2'b01, 0, 2, 1'b0, -1);
      len0 = 7'd2;
      req  = 2'b01;
      wait_start(n_start + 1);
      tick();
      req  = 2'b00;
      len0 = 7'd5;
      wait_cyc(start_cyc + 40);
      tick();
      spur_ind = 1'b1;
      tick();
      spur_ind = 1'b0;
      wait_evt(1);

      // Zero-length frame: PHR carries 00 and ends the frame, done at 105.
      push(2'b01, 0, 0, 1'b0, -1);
      len0 = 7'd0;
      tick();
      req = 2'b01;
      wait_start(n_start + 1);
      tick();
      req = 2'b00;
      wait_evt(2);

      // Reset asserted mid-PSDU (byte index 5): outputs drop at once, no done.
      len1 = 7'd10;
      tick();
      req = 2'b10;
      wait_start(n_start + 1);
      tick();
      req = 2'b00;
      wait_cyc(start_cyc + 89 + 8 * 5 + 3);
      #2 reset_n = 1'b0;
      #1 check("async_abort_outputs", all_outs(), 0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (2) tick();

      // Both requesting after reset: 01, 10, 01 with IFS GAP + one IDLE between.
      push(2'b01, 0, 1, 1'b0, -1);
      push(2'b10, 1, 3, 1'b0, IFS + 2);
      push(2'b01, 0, 1, 1'b0, IFS + 2);
      len0 = 7'd1;
      len1 = 7'd3;
      req  = 2'b11;
      wait_start(n_start + 3);
      tick();
      req = 2'b00;
      wait_evt(5);

      // Longest frame: 127 bytes, done 1121 cycles after START.
      push(2'b10, 1, 127, 1'b0, -1);
      len1 = 7'd127;
      tick();
      req = 2'b10;
      wait_start(n_start + 1);
      tick();
      req = 2'b00;
      wait_evt(6);

      // Silent framer.
      framer_en = 1'b0;
      len0      = 7'd1;
      repeat (8) tick();
`ifdef FRAMING_SCHED_TIMEOUT_EN
      push(2'b01, 0, 1, 1'b1, -1);
      req = 2'b01;
      wait_start(n_start + 1);
      tick();
      req = 2'b00;
      wait_evt(7);
      wait_cyc(evt_cyc + 1);
      check("grant_after_timeout", 32'(grant), 0);
      wait_cyc(evt_cyc + 4);
      check("busy_last_gap_cycle", 32'(busy), 1);
      wait_cyc(evt_cyc + 5);
      check("idle_after_gap", 32'(busy), 0);
`else
      req = 2'b01;
      wait_start(n_start + 1);
      tick();
      req = 2'b00;
      wait_cyc(start_cyc + 200);
      check("fcs_wait_busy_held", 32'(busy), 1);
      check("fcs_wait_grant_held", 32'(grant), 32'(2'b01));
      check("err_tied_low", 32'(err), 0);
`endif
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check("final_reset_outputs", all_outs(), 0);
      framer_en = 1'b1;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();

      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
